// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared FSM state encoding and seven-segment code table for the 1011 detector
package detector_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam int NUM_DIGITS = 10;

  // Active-low codes ordered {dp,g,f,e,d,c,b,a}; dp is always off (bit 7 = 1)
  localparam logic [7:0] SEG_CODES [NUM_DIGITS] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational digit to seven-segment code decode
module seg7_decoder
  import detector_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [7:0] code
);

  logic [7:0] code_lo;

  always_comb begin
    code_lo = SEG_BLANK;
    if (digit < 4'(NUM_DIGITS)) begin
      code_lo = SEG_CODES[digit];
    end
    code = ACTIVE_LOW ? code_lo : ~code_lo;
  end

endmodule

// File: rtl/detector.sv
// rtl/detector.sv - overlapping 1011 serial pattern detector with mod-10 match count on a seven-segment display
module detector
  import detector_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic [7:0] seg
);

  localparam logic [7:0] SEG_ZERO = SEG_ACTIVE_LOW ? SEG_CODES[0] : ~SEG_CODES[0];

  state_t     state;
  state_t     state_nx;
  logic [3:0] count;
  logic [7:0] seg_code;

  always_comb begin
    state_nx = S0;
    case (state)
      S0:      state_nx = din ? S1    : S0;
      S1:      state_nx = din ? S1    : S10;
      S10:     state_nx = din ? S101  : S0;
      S101:    state_nx = din ? S1011 : S10;
      S1011:   state_nx = din ? S1    : S10;
      default: state_nx = S0;
    endcase
  end

  seg7_decoder #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg7_decoder (
    .digit(count),
    .code (seg_code)
  );

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= S0;
      count <= 4'd0;
      dout  <= 1'b0;
      seg   <= SEG_ZERO;
    end else begin
      state <= state_nx;
      dout  <= (state_nx == S1011);
      if (state_nx == S1011) begin
        count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
      end
      seg <= seg_code;
    end
  end

endmodule

// File: tb/tb_detector.sv
// tb/tb_detector.sv - scoreboard bench for the 1011 detector, active-low and active-high seg builds
module tb_detector;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       dout;
  logic [7:0] seg;
  logic       dout_hi;
  logic [7:0] seg_hi;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q [$];

  logic [3:0] hist;
  int         nbits;
  int         cnt;

  detector u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .seg  (seg)
  );

  detector #(
    .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout_hi),
    .seg  (seg_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_lo(int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: match whenever the last four sampled bits since reset read 1011
  task automatic drive_bit(input logic b);
    logic m;
    din = b;
    @(posedge clk);
    #1;
    hist = {hist[2:0], b};
    if (nbits < 4) nbits++;
    m = (nbits >= 4) && (hist == 4'b1011);
    exp_q.push_back({m, seg_lo(cnt)});
    if (m) cnt = (cnt == 9) ? 0 : cnt + 1;
  endtask

  task automatic drive_vec(input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      drive_bit(bits[i] == "1");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_dout", {7'd0, dout}, 8'h00);
    check("async_rst_seg", seg, 8'hC0);
    hist  = 4'd0;
    nbits = 0;
    cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = ~din;
      check("rst_dout", {7'd0, dout}, 8'h00);
      check("rst_seg", seg, 8'hC0);
      check("rst_seg_hi", seg_hi, 8'h3F);
    end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic check_now(input string name, input logic exp_dout, input logic [7:0] exp_seg);
    @(negedge clk);
    check({name, "_dout"}, {7'd0, dout}, {7'd0, exp_dout});
    check({name, "_seg"}, seg, exp_seg);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_dout", {7'd0, dout}, {7'd0, e[8]});
      check("sb_dout_hi", {7'd0, dout_hi}, {7'd0, e[8]});
      check("sb_seg", seg, e[7:0]);
      check("sb_seg_hi", seg_hi, ~e[7:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    din   = 1'b0;
    hist  = 4'd0;
    nbits = 0;
    cnt   = 0;

    do_reset();
    drive_vec("10110");
    check_now("single", 1'b0, 8'hF9);

    do_reset();
    drive_vec("10110110");
    check_now("overlap", 1'b0, 8'hA4);

    do_reset();
    for (int i = 0; i < 10; i++) drive_vec("1011");
    drive_vec("0");
    check_now("wrap", 1'b0, 8'hC0);

    drive_vec("101");
    do_reset();
    drive_vec("100");
    check_now("midrst", 1'b0, 8'hC0);

    do_reset();
    for (int burst = 0; burst < 4; burst++) begin
      for (int i = 0; i < 16; i++) drive_bit(1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
